// File: rtl/cam_emulator.sv
// OV7670-style pixel source: drives pclk/vsync/href and an RGB565 byte stream
// with fixed test patterns, one frame per request or back-to-back while enabled.
//
// state    | meaning
// S_IDLE   | no frame, waiting for enable at a pclk falling edge
// S_VSYNC  | vsync lines, CAM_vsync high
// S_VBACK  | blank lines after vsync
// S_ACTIVE | active lines, href high for the first 2*CAM_SCREEN_X pclk of a line
// S_VFRONT | blank lines after the last active line; frame_done at the end
module cam_emulator #(
   parameter int CAM_SCREEN_X = 160,
   parameter int CAM_SCREEN_Y = 120,
   parameter int H_BLANK      = 16,
   parameter int V_SYNC       = 3,
   parameter int V_BACK       = 2,
   parameter int V_FRONT      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] pattern,
   output logic       CAM_pclk,
   output logic       CAM_vsync,
   output logic       CAM_href,
   output logic [7:0] CAM_px_data,
   output logic       busy,
   output logic       frame_done
);

   localparam int LINE = 2 * CAM_SCREEN_X + H_BLANK;
   localparam int HW   = $clog2(LINE);
   localparam int VW   = $clog2(CAM_SCREEN_Y + V_SYNC + V_BACK + V_FRONT + 1);

   localparam logic [HW-1:0] H_LAST   = HW'(LINE - 1);
   localparam logic [HW-1:0] H_ACTIVE = HW'(2 * CAM_SCREEN_X);
   localparam logic [HW-1:0] X_THIRD  = HW'(CAM_SCREEN_X / 3);
   localparam logic [HW-1:0] X_2THIRD = HW'((2 * CAM_SCREEN_X) / 3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBACK,
      S_ACTIVE,
      S_VFRONT
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [VW-1:0]   vcnt_q, vcnt_d;
   logic [1:0]      pat_q, pat_d;
   logic            pclk_q, pclk_d;
   logic            vsync_q, vsync_d;
   logic            href_q, href_d;
   logic [7:0]      data_q, data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [VW-1:0]   vlast;
   logic            start;
   logic [HW-1:0]   px_x;
   logic [1:0]      color;
   logic [15:0]     pix;

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      pat_d   = pat_q;
      pclk_d  = ~pclk_q;
      vsync_d = vsync_q;
      href_d  = href_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      start   = 1'b0;
      px_x    = '0;
      color   = 2'd0;
      pix     = 16'h0000;

      case (state_q)
         S_VSYNC:  vlast = VW'(V_SYNC - 1);
         S_VBACK:  vlast = VW'(V_BACK - 1);
         S_ACTIVE: vlast = VW'(CAM_SCREEN_Y - 1);
         S_VFRONT: vlast = VW'(V_FRONT - 1);
         default:  vlast = '0;
      endcase

      // everything below advances only on the edge where pclk goes 1->0
      if (pclk_q) begin
         if (state_q == S_IDLE) begin
            start = enable;
         end else if (hcnt_q != H_LAST) begin
            hcnt_d = hcnt_q + HW'(1);
         end else begin
            hcnt_d = '0;
            if (vcnt_q != vlast) begin
               vcnt_d = vcnt_q + VW'(1);
            end else begin
               vcnt_d = '0;
               case (state_q)
                  S_VSYNC:  state_d = S_VBACK;
                  S_VBACK:  state_d = S_ACTIVE;
                  S_ACTIVE: state_d = S_VFRONT;
                  default: begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                     start   = enable;
                  end
               endcase
            end
         end

         if (start) begin
            state_d = S_VSYNC;
            hcnt_d  = '0;
            vcnt_d  = '0;
            pat_d   = pattern;
            busy_d  = 1'b1;
         end

         // outputs are registered from the upcoming position so they settle on the pclk fall
         px_x = hcnt_d >> 1;
         if (pat_d != 2'd3)          color = pat_d;
         else if (px_x < X_THIRD)    color = 2'd0;
         else if (px_x < X_2THIRD)   color = 2'd1;
         else                        color = 2'd2;
         case (color)
            2'd0:    pix = 16'hF800;
            2'd1:    pix = 16'h07E0;
            default: pix = 16'h001F;
         endcase

         vsync_d = (state_d == S_VSYNC);
         href_d  = (state_d == S_ACTIVE) && (hcnt_d < H_ACTIVE);
         data_d  = !href_d ? 8'h00 : (hcnt_d[0] ? pix[7:0] : pix[15:8]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         pat_q   <= 2'd0;
         pclk_q  <= 1'b0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         pat_q   <= pat_d;
         pclk_q  <= pclk_d;
         vsync_q <= vsync_d;
         href_q  <= href_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign CAM_pclk    = pclk_q;
   assign CAM_vsync   = vsync_q;
   assign CAM_href    = href_q;
   assign CAM_px_data = data_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_cam_emulator.sv
// Scoreboarded bench for cam_emulator on a small frame geometry with random patterns.
module tb_cam_emulator;

   localparam int X     = 6;
   localparam int Y     = 2;
   localparam int HB    = 2;
   localparam int VS    = 1;
   localparam int VB    = 1;
   localparam int VF    = 1;
   localparam int LINE  = 2 * X + HB;
   localparam int FRAME_CLK = 2 * LINE * (VS + VB + Y + VF);

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] pattern;
   logic       CAM_pclk, CAM_vsync, CAM_href, busy, frame_done;
   logic [7:0] CAM_px_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pending = 0;
   logic [7:0] exp_bytes[$];

   cam_emulator #(
      .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .H_BLANK(HB),
      .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
      .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
      .CAM_px_data(CAM_px_data), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference: Y lines of X RGB565 pixels, high byte first
   task automatic push_frame(input int pat);
      int col;
      logic [15:0] pix;
      for (int ln = 0; ln < Y; ln++) begin
         for (int x = 0; x < X; x++) begin
            if (pat != 3)          col = pat;
            else if (x < X / 3)    col = 0;
            else if (x < 2 * X / 3) col = 1;
            else                   col = 2;
            pix = (col == 0) ? 16'hF800 : (col == 1) ? 16'h07E0 : 16'h001F;
            exp_bytes.push_back(pix[15:8]);
            exp_bytes.push_back(pix[7:0]);
         end
      end
   endtask

   // byte stream monitor: sampled at the receiver's pclk rising edge
   int run = 0;
   always @(posedge CAM_pclk or negedge rst) begin
      if (!rst) begin
         run = 0;
      end else if (CAM_href) begin
         run++;
         if (exp_bytes.size() == 0) chk("unexpected_byte", 1, 0);
         else chk("px_byte", int'(CAM_px_data), int'(exp_bytes.pop_front()));
      end else begin
         chk("blank_data_zero", int'(CAM_px_data), 0);
         if (run != 0) chk("href_run_len", run, 2 * X);
         run = 0;
      end
   end

   // frame timing monitor
   logic       vs_prev = 1'b0, done_prev = 1'b0, have_start = 1'b0, seen_href = 1'b0;
   logic [9:0] out_prev = '0;
   int         start_cyc = 0;
   always @(negedge clk) begin
      if (!rst) begin
         vs_prev = 1'b0; done_prev = 1'b0; have_start = 1'b0; seen_href = 1'b0;
         out_prev = '0;
      end else begin
         if ({CAM_vsync, CAM_href, CAM_px_data} != out_prev) chk("change_off_pclk_fall", int'(CAM_pclk), 0);
         if (frame_done) begin
            chk("done_width", int'(done_prev), 0);
            if (have_start) chk("frame_len", cyc - start_cyc, FRAME_CLK);
            chk("done_expected", int'(pending > 0), 1);
            if (pending > 0) pending--;
            have_start = 1'b0;
         end
         if (CAM_vsync && !vs_prev) begin
            start_cyc = cyc; have_start = 1'b1; seen_href = 1'b0;
            chk("busy_at_vsync", int'(busy), 1);
         end
         if (!CAM_vsync && vs_prev) chk("vsync_width", cyc - start_cyc, 2 * VS * LINE);
         if (CAM_href && !seen_href && have_start) begin
            seen_href = 1'b1;
            chk("href_delay", cyc - start_cyc, 2 * (VS + VB) * LINE);
         end
         vs_prev = CAM_vsync; done_prev = frame_done;
         out_prev = {CAM_vsync, CAM_href, CAM_px_data};
      end
   end

   task automatic wait_vsync();
      int lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (CAM_vsync) begin lat = i; break; end
      end
      chk("start_latency_ok", int'(lat >= 1 && lat <= 2), 1);
   endtask

   task automatic wait_done(output int c);
      c = -1;
      for (int i = 0; i < 2 * FRAME_CLK; i++) begin
         @(negedge clk);
         if (frame_done) begin c = cyc; break; end
      end
      if (c < 0) chk("frame_done_timeout", 0, 1);
   endtask

   task automatic run_single(input int p);
      int d;
      pattern = 2'(p);
      push_frame(p);
      pending++;
      enable = 1'b1;
      wait_vsync();
      enable = 1'b0;
      wait_done(d);
      @(negedge clk);
      chk("busy_low_after", int'(busy), 0);
   endtask

   initial begin
      int p0, p1, p2, d1, d2, d3;
      rst = 1'b0; enable = 1'b0; pattern = 2'd0;
      repeat (3) @(negedge clk);
      chk("rst_pclk", int'(CAM_pclk), 0);
      chk("rst_vsync", int'(CAM_vsync), 0);
      chk("rst_href", int'(CAM_href), 0);
      chk("rst_data", int'(CAM_px_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      p0 = int'(CAM_pclk);
      @(negedge clk);
      chk("pclk_toggle", int'(CAM_pclk), 1 - p0);

      for (int f = 0; f < 4; f++) begin
         run_single((f == 0) ? 0 : (f == 1) ? 3 : int'($urandom_range(0, 3)));
         repeat ($urandom_range(1, 7)) @(negedge clk);
      end

      // back-to-back frames with a pattern change during frame 2
      p1 = int'($urandom_range(0, 3));
      p2 = (p1 + 1 + int'($urandom_range(0, 2))) % 4;
      pattern = 2'(p1);
      push_frame(p1);
      pending++;
      enable = 1'b1;
      wait_vsync();
      wait_done(d1);
      push_frame(p1);
      pending++;
      repeat (60) @(negedge clk);
      pattern = 2'(p2);
      push_frame(p2);
      pending++;
      wait_done(d2);
      chk("b2b_spacing_1", d2 - d1, FRAME_CLK);
      repeat (30) @(negedge clk);
      enable = 1'b0;
      wait_done(d3);
      chk("b2b_spacing_2", d3 - d2, FRAME_CLK);
      repeat (4) @(negedge clk);
      chk("busy_low_after_b2b", int'(busy), 0);
      repeat (10) @(negedge clk);
      chk("no_extra_frame", int'(CAM_vsync), 0);

      // asynchronous reset in the middle of an active line
      pattern = 2'($urandom_range(0, 3));
      push_frame(int'(pattern));
      pending++;
      enable = 1'b1;
      wait_vsync();
      enable = 1'b0;
      begin
         int waited = 0;
         while (!CAM_href && waited < 2 * FRAME_CLK) begin @(negedge clk); waited++; end
         chk("href_seen_before_reset", int'(CAM_href), 1);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_pclk", int'(CAM_pclk), 0);
      chk("arst_vsync", int'(CAM_vsync), 0);
      chk("arst_href", int'(CAM_href), 0);
      chk("arst_data", int'(CAM_px_data), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(frame_done), 0);
      exp_bytes.delete();
      pending = 0;
      repeat (10) @(negedge clk);
      pattern = 2'($urandom_range(0, 3));
      push_frame(int'(pattern));
      pending = 1;
      enable = 1'b1;
      rst = 1'b1;
      wait_vsync();
      enable = 1'b0;
      wait_done(d1);
      @(negedge clk);
      chk("busy_low_after_rst_frame", int'(busy), 0);

      repeat (5) @(negedge clk);
      chk("pending_frames_left", pending, 0);
      chk("bytes_left", exp_bytes.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
